// File: rtl/uart_rx_core_if.sv
// ============================================================================
// Module   : uart_rx_core_if
// Brief    : Serial input plus byte valid/ready bundle for uart_rx_core.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_rx_core_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx;
   logic [DATA_BITS-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   // master: the receiver, which produces bytes from the serial line
   modport master (
      input  rx,
      input  out_ready,
      output out_data,
      output out_valid,
      output frame_err,
      output parity_err,
      output overrun
   );

   modport slave (
      output rx,
      output out_ready,
      input  out_data,
      input  out_valid,
      input  frame_err,
      input  parity_err,
      input  overrun
   );
endinterface

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module   : uart_rx_core
// Brief    : UART receiver with mid-bit sampling and a one-entry valid/ready
//            holding register. Define UART_RX_PARITY_EN to add a parity bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_core #(
   parameter int CLK_PER_BIT = 16,
   parameter int DATA_BITS   = 8,
   parameter bit PARITY_ODD  = 1'b0
) (
   input  wire logic      clk,
   input  wire logic      reset,
   uart_rx_core_if.master bus
);

   localparam int c_HALF = CLK_PER_BIT / 2;
   localparam int c_CW   = $clog2(CLK_PER_BIT);
   localparam int c_IW   = $clog2(DATA_BITS);
   localparam logic [c_CW-1:0] c_CNT_MID  = c_CW'(c_HALF - 1);
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLK_PER_BIT - 1);
   localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;
`endif

   state_t               r_state;
   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic [c_CW-1:0]      r_cnt;
   logic [c_IW-1:0]      r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_ferr;
   logic                 r_perr;
   logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bad;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_perr    <= 1'b0;
         r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad <= 1'b0;
`endif
      end else begin
         r_rx_meta <= bus.rx;
         r_rx_s    <= r_rx_meta;
         r_overrun <= 1'b0;
         r_cnt     <= r_cnt + c_CW'(1);

         if (r_valid && bus.out_ready)
            r_valid <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (!r_rx_s)
                  r_state <= S_START;
            end
            S_START: begin
               if (r_cnt == c_CNT_MID) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= r_rx_s ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (r_cnt == c_CNT_LAST) begin
                  r_cnt          <= '0;
                  r_shift[r_idx] <= r_rx_s;
                  if (r_idx == c_IDX_LAST) begin
                     r_idx <= '0;
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_idx <= r_idx + c_IW'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (r_cnt == c_CNT_LAST) begin
                  r_cnt     <= '0;
                  r_par_bad <= (^r_shift) ^ r_rx_s ^ PARITY_ODD;
                  r_state   <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (r_cnt == c_CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= r_rx_s ? S_IDLE : S_BREAK;
                  // A handshake on this edge frees the slot for the new byte
                  if (!r_valid || bus.out_ready) begin
                     r_data  <= r_shift;
                     r_ferr  <= ~r_rx_s;
                     r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     r_perr  <= r_par_bad;
`else
                     r_perr  <= 1'b0 & PARITY_ODD;
`endif
                  end else begin
                     r_overrun <= 1'b1;
                  end
               end
            end
            S_BREAK: begin
               r_cnt <= '0;
               if (r_rx_s)
                  r_state <= S_IDLE;
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.out_data   = r_data;
   assign bus.out_valid  = r_valid;
   assign bus.frame_err  = r_ferr;
   assign bus.parity_err = r_perr;
   assign bus.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Directed bench for uart_rx_core, table of frames plus sequences
//            for glitch, break, overrun and mid-frame reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

   localparam int CPB = 16;
   localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int LAT = 2 + CPB / 2 + (DB + P + 1) * CPB;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   t0     = 0;

   uart_rx_core_if #(.DATA_BITS(DB)) bus ();

   uart_rx_core #(
      .CLK_PER_BIT (CPB),
      .DATA_BITS   (DB),
      .PARITY_ODD  (1'b0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
   } acc_t;

   typedef struct {
      logic [7:0] data;
      logic       pbit;
      logic       stop;
      logic [7:0] e_data;
      logic       e_ferr;
      logic       e_perr;
   } vec_t;

   int   rise_q[$];
   int   ovr_q[$];
   acc_t acc_q[$];
   logic prev_valid = 1'b0;
   vec_t vecs[6];

   always @(negedge clk) begin
      acc_t a;
      if (bus.out_valid && !prev_valid)
         rise_q.push_back(cyc);
      prev_valid = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
         a.data = bus.out_data;
         a.ferr = bus.frame_err;
         a.perr = bus.parity_err;
         acc_q.push_back(a);
      end
      if (bus.overrun)
         ovr_q.push_back(cyc);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_q();
      rise_q.delete();
      ovr_q.delete();
      acc_q.delete();
   endtask

   // Called one step after a rising edge; the next edge is e0
   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
      bus.rx = 1'b0;
      t0 = cyc + 1;
      tick(CPB);
      for (int i = 0; i < DB; i++) begin
         bus.rx = d[i];
         tick(CPB);
      end
      if (P == 1) begin
         bus.rx = pbit;
         tick(CPB);
      end
      bus.rx = stop;
      tick(CPB);
   endtask

   task automatic check_frame(input string name, input logic [7:0] ed, input logic ef, input logic ep);
      chk({name, " rises"}, rise_q.size(), 1);
      if (rise_q.size() > 0)
         chk({name, " latency"}, rise_q[0] - t0, LAT);
      chk({name, " accepted"}, acc_q.size(), 1);
      if (acc_q.size() > 0) begin
         chk({name, " data"}, acc_q[0].data, ed);
         chk({name, " frame_err"}, acc_q[0].ferr, ef);
         chk({name, " parity_err"}, acc_q[0].perr, ep);
      end
      chk({name, " overruns"}, ovr_q.size(), 0);
   endtask

   initial begin
      logic [7:0] d55;
      int         t0a;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
      vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
      vecs[5] = '{8'hC3, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};

      bus.rx        = 1'b1;
      bus.out_ready = 1'b1;
      reset         = 1'b1;
      tick(3);
      chk("reset out_data", bus.out_data, 8'h00);
      chk("reset out_valid", bus.out_valid, 1'b0);
      chk("reset frame_err", bus.frame_err, 1'b0);
      chk("reset parity_err", bus.parity_err, 1'b0);
      chk("reset overrun", bus.overrun, 1'b0);
      reset = 1'b0;
      tick(2 * CPB);

      // Short low pulse must be rejected at the start-bit check
      clear_q();
      bus.rx = 1'b0;
      tick(4);
      bus.rx = 1'b1;
      tick(40);
      chk("glitch rises", rise_q.size(), 0);
      chk("glitch out_valid", bus.out_valid, 1'b0);

      for (int i = 0; i < 6; i++) begin
         clear_q();
         send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stop);
         bus.rx = 1'b1;
         tick(2 * CPB);
         check_frame($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_ferr,
                     (P == 1) ? vecs[i].e_perr : 1'b0);
      end

      // Bad stop bit followed by a held-low line
      clear_q();
      send_frame(8'h81, 1'b0, 1'b0);
      tick(40);
      chk("break still idle", rise_q.size(), 1);
      bus.rx = 1'b1;
      tick(2 * CPB);
      check_frame("break", 8'h81, 1'b1, 1'b0);

      // Back-to-back frames with the consumer stalled
      clear_q();
      bus.out_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1);
      t0a = t0;
      send_frame(8'h22, 1'b0, 1'b1);
      bus.rx = 1'b1;
      tick(CPB);
      chk("ovr rises", rise_q.size(), 1);
      if (rise_q.size() > 0)
         chk("ovr first latency", rise_q[0] - t0a, LAT);
      chk("ovr pulses", ovr_q.size(), 1);
      if (ovr_q.size() > 0)
         chk("ovr pulse edge", ovr_q[0] - t0, LAT);
      chk("ovr held data", bus.out_data, 8'h11);
      chk("ovr held valid", bus.out_valid, 1'b1);
      bus.out_ready = 1'b1;
      tick(3);
      chk("ovr accepted", acc_q.size(), 1);
      if (acc_q.size() > 0)
         chk("ovr accepted data", acc_q[0].data, 8'h11);
      chk("ovr drained valid", bus.out_valid, 1'b0);

      // Reset in the middle of DATA while a byte is held
      clear_q();
      bus.out_ready = 1'b0;
      send_frame(8'h77, 1'b0, 1'b1);
      bus.rx = 1'b1;
      tick(CPB);
      chk("pre-reset valid", bus.out_valid, 1'b1);
      chk("pre-reset data", bus.out_data, 8'h77);
      d55 = 8'h55;
      bus.rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         bus.rx = d55[i];
         tick(CPB);
      end
      reset  = 1'b1;
      bus.rx = 1'b1;
      tick(1);
      chk("midreset out_data", bus.out_data, 8'h00);
      chk("midreset out_valid", bus.out_valid, 1'b0);
      chk("midreset frame_err", bus.frame_err, 1'b0);
      chk("midreset parity_err", bus.parity_err, 1'b0);
      chk("midreset overrun", bus.overrun, 1'b0);
      reset = 1'b0;
      clear_q();
      tick(3 * CPB);
      chk("midreset no byte", rise_q.size(), 0);
      bus.out_ready = 1'b1;
      clear_q();
      send_frame(8'h66, 1'b0, 1'b1);
      bus.rx = 1'b1;
      tick(2 * CPB);
      check_frame("post-reset", 8'h66, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable UART receiver that deserializes the `rx` line of the UART pin interface into parallel bytes. It sits on the DUT side of the `tx`/`rx` pair, opposite the transmitting agent. It samples each bit at mid-period using a clock-per-bit counter, optionally checks parity, flags framing and overrun errors, and presents each byte through a one-entry valid/ready holding register.

## Interface
- `CLK_PER_BIT`, default 16: clock cycles per UART bit; even, ≥ 4; HALF = CLK_PER_BIT/2.
- `DATA_BITS`, default 8: data bits per frame, 5..8, sent LSB first.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Used only when parity is compiled in.
- `clk` in 1: the block's only clock.
- `reset` in 1: synchronous, active-high reset.
- `rx` in 1: serial input; idle level is 1. Asynchronous to `clk`.
- `out_data` out DATA_BITS: received byte.
- `out_valid` out 1: `out_data` holds an unconsumed byte.
- `out_ready` in 1: consumer accepts the byte when `out_valid && out_ready`.
- `frame_err` out 1: stop bit of the held byte was sampled as 0. Valid while `out_valid`.
- `parity_err` out 1: parity mismatch on the held byte. Valid while `out_valid`.
- `overrun` out 1: one-cycle pulse when a completed byte is dropped.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- The bit counter `cnt` is $clog2(CLK_PER_BIT) bits wide and clears on every state change.
- States and transitions:
  - IDLE: `rx_s==0` → START.
  - START: at `cnt==HALF-1`, sample `rx_s`. If 0 → DATA. If 1 → IDLE (glitch rejected; nothing is reported).
  - DATA: at `cnt==CLK_PER_BIT-1`, shift `rx_s` into shift reg bit `idx` (LSB first). After `DATA_BITS` samples → PARITY, or → STOP if parity is compiled out.
  - PARITY: at `cnt==CLK_PER_BIT-1`, sample the parity bit, compute the mismatch, then → STOP.
  - STOP: at `cnt==CLK_PER_BIT-1`, sample the stop bit and complete the frame. If `rx_s==1` → IDLE. If `rx_s==0` → BREAK.
  - BREAK: wait for `rx_s==1`, then → IDLE. This prevents a held-low line from retriggering.
- Frame completion rules:
  - If the holding register is free (`!out_valid`), or is handshaking in the same cycle, load `out_data`, `frame_err`, `parity_err` and set `out_valid=1`.
  - Otherwise drop the new byte, keep the held byte and errors unchanged, and pulse `overrun` for 1 cycle.
- A byte with a framing error is still delivered, with `frame_err=1`.
- Handshake:
  - `out_valid` clears on the edge after `out_valid && out_ready`, unless a new byte loads on that same edge; in that case `out_valid` stays 1 and the new data appears.
  - `out_valid` never drops without a handshake.
- Reset values: state IDLE; `cnt`, shift reg and `out_data` = 0; `out_valid`, `frame_err`, `parity_err`, `overrun` = 0.
- Reset mid-frame abandons the frame with no output. The block re-arms in IDLE and needs `rx_s` low again to start.

## Timing
- Let e0 be the first clock edge that samples `rx=0`.
- START is entered at e2.
- The start bit is checked at e(2+HALF).
- Data bit k is sampled at e(2+HALF+(k+1)·CLK_PER_BIT).
- `out_valid` rises at edge e(2+HALF+N·CLK_PER_BIT), where N = DATA_BITS+P+1 and P = 1 with parity, 0 without.
  - Defaults, parity on: e170.
  - Defaults, parity off: e154.
- The earliest next start detection is the edge after the STOP sample. This allows back-to-back frames at 1-bit-period spacing.
- `overrun` is registered at the STOP-sample edge and is high for exactly one cycle.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: PARITY state present; N includes the parity bit; `parity_err` reports mismatch per `PARITY_ODD`.
  - Undefined: no PARITY state; frame is start + DATA_BITS + stop; `parity_err` tied to 0; `PARITY_ODD` ignored.

## Test plan
- Default params, parity on, send 0xA5 with even-parity bit 0 and stop 1, `out_ready=1` → `out_valid` at e170 for 1 cycle, `out_data=0xA5`, both error flags 0.
- Hold `rx` low for 4 cycles, then high → START aborts at e10; `out_valid` never asserts; block returns to IDLE.
- Send 0x3C with parity bit 1 (wrong) → `out_data=0x3C`, `parity_err=1`, `frame_err=0`.
- Send 0x81 with stop bit 0, then hold `rx` low for 40 cycles → byte delivered with `frame_err=1`; no second frame until `rx` returns high.
- With `out_ready=0`, send 0x11 then 0x22 back-to-back → `out_data` stays 0x11, `overrun` pulses once at the second STOP sample. Raising `out_ready` then yields 0x11 only.
- Assert `reset` mid-DATA of a 0x55 frame → all outputs 0 next edge, no byte delivered. A following clean 0x66 frame is received correctly.
